// File: rtl/bist_engine.sv
// Logic BIST controller: an LFSR drives the circuit under test and a MISR compacts its responses.
// Optional scan-chain sequencing is enabled by defining BIST_SCAN_EN.
module bist_engine #(
  parameter int unsigned        IN_W       = 3,
  parameter int unsigned        OUT_W      = 3,
  parameter int unsigned        LFSR_W     = 8,
  parameter logic [LFSR_W-1:0]  LFSR_POLY  = 8'hB8,
  parameter logic [LFSR_W-1:0]  LFSR_SEED  = 8'h01,
  parameter int unsigned        SIG_W      = 8,
  parameter logic [SIG_W-1:0]   MISR_POLY  = 8'hB8,
  parameter logic [SIG_W-1:0]   GOLDEN_SIG = 8'h00,
  parameter int unsigned        N_PATTERNS = 16,
  parameter int unsigned        RESP_LAT   = 1
`ifdef BIST_SCAN_EN
  ,
  parameter int unsigned        SCAN_LEN   = 4
`endif
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [IN_W-1:0]  func_in,
  output logic [IN_W-1:0]  cut_in,
  input  logic [OUT_W-1:0] cut_out,
  output logic             test_mode,
  output logic             RUNNING,
  output logic             BIST_END,
  output logic             PASS_FAIL,
`ifdef BIST_SCAN_EN
  output logic             scan_en,
  output logic             scan_in,
  input  logic             scan_out,
`endif
  output logic [SIG_W-1:0] signature
);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StInit    = 3'd1;
  localparam logic [2:0] StRun     = 3'd2;
  localparam logic [2:0] StCompare = 3'd3;
  localparam logic [2:0] StDone    = 3'd4;

`ifdef BIST_SCAN_EN
  localparam int unsigned PAT_CYC = SCAN_LEN + 1;
  localparam int unsigned PH_W    = $clog2(SCAN_LEN + 1);
`else
  localparam int unsigned PAT_CYC = 1;
`endif
  localparam int unsigned CNT_W   = $clog2(N_PATTERNS + 1);
  localparam int unsigned RUN_LEN = PAT_CYC * N_PATTERNS + RESP_LAT;
  localparam int unsigned RUN_W   = $clog2(RUN_LEN + 1);

  logic [2:0]        state_q, state_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d, lfsr_next;
  logic [SIG_W-1:0]  misr_q, misr_d, misr_next, resp_ext;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic              pass_q, pass_d;
  logic              pat_active, step_lfsr, apply, vld;

  assign pat_active = (state_q == StRun) && (cnt_q < CNT_W'(N_PATTERNS));

`ifdef BIST_SCAN_EN
  logic [PH_W-1:0] ph_q, ph_d;
  logic            shift;

  // Each pattern is SCAN_LEN shift cycles followed by one capture cycle.
  assign shift     = pat_active && (ph_q != PH_W'(SCAN_LEN));
  assign apply     = pat_active && (ph_q == PH_W'(SCAN_LEN));
  assign step_lfsr = shift;
  assign scan_en   = shift;
  assign scan_in   = lfsr_q[0];
`else
  assign apply     = pat_active;
  assign step_lfsr = pat_active;
`endif

  // Response-valid flag aligned to the CUT latency.
  generate
    if (RESP_LAT == 0) begin : g_no_lat
      assign vld = apply;
    end else begin : g_lat
      logic [RESP_LAT-1:0] vld_pipe_q;
      always_ff @(posedge CLK) begin
        if (RST || (state_q == StInit)) begin
          vld_pipe_q <= '0;
        end else begin
          vld_pipe_q[0] <= apply;
          for (int i = 1; i < int'(RESP_LAT); i++) vld_pipe_q[i] <= vld_pipe_q[i-1];
        end
      end
      assign vld = vld_pipe_q[RESP_LAT-1];
    end
  endgenerate

  always_comb begin
    resp_ext = '0;
    resp_ext[OUT_W-1:0] = cut_out;
  end

  assign lfsr_next = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_POLY)};
  assign misr_next = {misr_q[SIG_W-2:0], 1'b0} ^ (misr_q[SIG_W-1] ? MISR_POLY : '0) ^ resp_ext;

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    misr_d  = misr_q;
    cnt_d   = cnt_q;
    run_d   = run_q;
    pass_d  = pass_q;
`ifdef BIST_SCAN_EN
    ph_d    = ph_q;
`endif
    case (state_q)
      StIdle: begin
        if (START) state_d = StInit;
      end
      StInit: begin
        lfsr_d  = LFSR_SEED;
        misr_d  = '0;
        cnt_d   = '0;
        run_d   = '0;
        pass_d  = 1'b0;
`ifdef BIST_SCAN_EN
        ph_d    = '0;
`endif
        state_d = StRun;
      end
      StRun: begin
        if (step_lfsr) lfsr_d = lfsr_next;
        if (apply) cnt_d = cnt_q + CNT_W'(1);
        if (vld) misr_d = misr_next;
`ifdef BIST_SCAN_EN
        if (shift) misr_d[0] = misr_d[0] ^ scan_out;
        if (pat_active) ph_d = apply ? '0 : ph_q + PH_W'(1);
`endif
        run_d = run_q + RUN_W'(1);
        if (run_q == RUN_W'(RUN_LEN - 1)) state_d = StCompare;
      end
      StCompare: begin
        pass_d  = (misr_q == GOLDEN_SIG);
        state_d = StDone;
      end
      StDone: begin
        if (!START) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      lfsr_q  <= LFSR_SEED;
      misr_q  <= '0;
      cnt_q   <= '0;
      run_q   <= '0;
      pass_q  <= 1'b0;
`ifdef BIST_SCAN_EN
      ph_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      misr_q  <= misr_d;
      cnt_q   <= cnt_d;
      run_q   <= run_d;
      pass_q  <= pass_d;
`ifdef BIST_SCAN_EN
      ph_q    <= ph_d;
`endif
    end
  end

  assign test_mode = (state_q == StInit) || (state_q == StRun);
  assign RUNNING   = test_mode || (state_q == StCompare);
  assign BIST_END  = (state_q == StDone);
  assign PASS_FAIL = pass_q;
  assign signature = misr_q;
  assign cut_in    = test_mode ? lfsr_q[IN_W-1:0] : func_in;

endmodule

// File: tb/tb_bist_engine.sv
// Bench for bist_engine (default build): registered CUT model, signature model folded over the
// pattern sequence, per-cycle status checks and randomized functional inputs / START noise.
module tb_bist_engine;

  localparam int N    = 16;
  localparam int LAT  = 1;
  localparam int DONE = 3 + N + LAT;
  localparam logic [7:0] SEED = 8'h01;
  localparam logic [7:0] POLY = 8'hB8;

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], ^(s & POLY)};
  endfunction

  function automatic logic [7:0] misr_step(input logic [7:0] m, input logic [2:0] d);
    return {m[6:0], 1'b0} ^ (m[7] ? POLY : 8'h00) ^ {5'b0, d};
  endfunction

  // Signature of N patterns through a pass-through CUT, optionally with bit 0 stuck low.
  function automatic logic [7:0] model_sig(input bit stuck);
    logic [7:0] l, m;
    logic [2:0] d;
    l = SEED;
    m = 8'h00;
    for (int i = 0; i < N; i++) begin
      d = l[2:0];
      if (stuck) d[0] = 1'b0;
      m = misr_step(m, d);
      l = lfsr_step(l);
    end
    return m;
  endfunction

  localparam logic [7:0] GOLD = model_sig(1'b0);

  logic       clk = 1'b0;
  logic       rst, start;
  logic [2:0] func_in, cut_in, cut_out, cut_reg;
  logic       test_mode, running, bist_end, pass_fail;
  logic [7:0] signature;
  bit         stuck = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] pat [0:N];
  logic       obs_run [1:40];
  logic       obs_tm  [1:40];
  logic       obs_end [1:40];
  logic       obs_pf  [1:40];
  logic [2:0] obs_cut [1:40];
  logic [2:0] obs_func[1:40];
  logic [7:0] obs_sig [1:40];

  bist_engine #(.GOLDEN_SIG(GOLD)) dut (
    .CLK       (clk),
    .RST       (rst),
    .START     (start),
    .func_in   (func_in),
    .cut_in    (cut_in),
    .cut_out   (cut_out),
    .test_mode (test_mode),
    .RUNNING   (running),
    .BIST_END  (bist_end),
    .PASS_FAIL (pass_fail),
    .signature (signature)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cut_reg <= cut_in;
  assign cut_out = stuck ? {cut_reg[2:1], 1'b0} : cut_reg;

  // Issues START from IDLE and records outputs for cycles 1..ncyc after the sampling edge.
  task automatic run_bist(input bit hold, input int ncyc);
    start   = 1'b1;
    func_in = 3'($urandom);
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk);
      @(negedge clk);
      obs_run[c]  = running;
      obs_tm[c]   = test_mode;
      obs_end[c]  = bist_end;
      obs_pf[c]   = pass_fail;
      obs_cut[c]  = cut_in;
      obs_func[c] = func_in;
      obs_sig[c]  = signature;
      if (hold) start = 1'b1;
      else if (c < DONE - 1) start = 1'($urandom_range(0, 1));
      else start = 1'b0;
      func_in = 3'($urandom);
    end
  endtask

  function automatic int first_end(input int ncyc);
    for (int c = 1; c <= ncyc; c++) if (obs_end[c]) return c;
    return -1;
  endfunction

  task automatic test_reset;
    rst     = 1'b1;
    start   = 1'b1;
    func_in = 3'($urandom);
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({running, bist_end, pass_fail, test_mode} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 0000", {running, bist_end, pass_fail, test_mode});
    end
    n_checks++;
    if (signature !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_sig: got %h want 00", signature);
    end
    n_checks++;
    if (cut_in !== func_in) begin
      n_fail++;
      $display("FAIL reset_cut_in: got %h want %h", cut_in, func_in);
    end
    rst   = 1'b0;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (running !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: running got %b want 0", running);
    end
  endtask

  task automatic test_idle_passthrough;
    int gap;
    gap   = $urandom_range(2, 6);
    start = 1'b0;
    for (int i = 0; i < gap; i++) begin
      func_in = 3'($urandom);
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (cut_in !== func_in || test_mode !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_passthrough: cut_in %h tm %b want %h tm 0", cut_in, test_mode, func_in);
      end
    end
  endtask

  task automatic test_pass_run;
    logic [2:0] exp_cut;
    run_bist(1'b0, DONE + 4);
    for (int c = 1; c <= DONE + 4; c++) begin
      n_checks++;
      if (obs_run[c] !== (c <= DONE - 1)) begin
        n_fail++;
        $display("FAIL running_c%0d: got %b want %b", c, obs_run[c], c <= DONE - 1);
      end
      n_checks++;
      if (obs_tm[c] !== (c <= DONE - 2)) begin
        n_fail++;
        $display("FAIL test_mode_c%0d: got %b want %b", c, obs_tm[c], c <= DONE - 2);
      end
      n_checks++;
      if (obs_end[c] !== (c == DONE)) begin
        n_fail++;
        $display("FAIL bist_end_c%0d: got %b want %b", c, obs_end[c], c == DONE);
      end
      if (c >= 2) begin
        exp_cut = (c <= DONE - 2) ? pat[(c - 2 < N) ? c - 2 : N][2:0] : obs_func[c];
        n_checks++;
        if (obs_cut[c] !== exp_cut) begin
          n_fail++;
          $display("FAIL cut_in_c%0d: got %h want %h", c, obs_cut[c], exp_cut);
        end
      end
    end
    n_checks++;
    if (obs_sig[DONE] !== GOLD) begin
      n_fail++;
      $display("FAIL pass_signature: got %h want %h", obs_sig[DONE], GOLD);
    end
    n_checks++;
    if (obs_pf[DONE] !== 1'b1 || obs_pf[DONE + 4] !== 1'b1) begin
      n_fail++;
      $display("FAIL pass_flag: got %b/%b want 1/1", obs_pf[DONE], obs_pf[DONE + 4]);
    end
  endtask

  task automatic test_stuck_fault;
    logic [7:0] bad;
    bad   = model_sig(1'b1);
    stuck = 1'b1;
    run_bist(1'b0, DONE + 2);
    stuck = 1'b0;
    n_checks++;
    if (first_end(DONE + 2) != DONE) begin
      n_fail++;
      $display("FAIL stuck_end_cycle: got %0d want %0d", first_end(DONE + 2), DONE);
    end
    n_checks++;
    if (obs_pf[DONE] !== 1'b0) begin
      n_fail++;
      $display("FAIL stuck_pass_flag: got %b want 0", obs_pf[DONE]);
    end
    n_checks++;
    if (obs_sig[DONE] === GOLD || obs_sig[DONE] !== bad) begin
      n_fail++;
      $display("FAIL stuck_signature: got %h want %h (golden %h)", obs_sig[DONE], bad, GOLD);
    end
  endtask

  task automatic test_reset_mid_run;
    run_bist(1'b0, 10);
    start = 1'b0;
    rst   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({test_mode, running, bist_end} !== 3'b000 || cut_in !== func_in) begin
      n_fail++;
      $display("FAIL mid_reset: tm/run/end %b cut_in %h want 000 cut_in %h",
               {test_mode, running, bist_end}, cut_in, func_in);
    end
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (signature !== 8'h00) begin
      n_fail++;
      $display("FAIL mid_reset_sig: got %h want 00", signature);
    end
    run_bist(1'b0, DONE + 2);
    n_checks++;
    if (obs_sig[DONE] !== GOLD || obs_pf[DONE] !== 1'b1) begin
      n_fail++;
      $display("FAIL rerun_after_reset: sig %h pf %b want %h pf 1", obs_sig[DONE], obs_pf[DONE], GOLD);
    end
  endtask

  task automatic test_start_hold;
    run_bist(1'b1, DONE + 10);
    for (int c = DONE; c <= DONE + 10; c++) begin
      n_checks++;
      if (obs_end[c] !== 1'b1 || obs_run[c] !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_done_c%0d: end %b run %b want 1 0", c, obs_end[c], obs_run[c]);
      end
    end
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bist_end !== 1'b0 || running !== 1'b0 || pass_fail !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_release: end %b run %b pf %b want 0 0 1", bist_end, running, pass_fail);
    end
    run_bist(1'b0, DONE + 2);
    n_checks++;
    if (obs_run[1] !== 1'b1 || obs_pf[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_init: run %b pf %b want 1 0", obs_run[1], obs_pf[2]);
    end
    n_checks++;
    if (first_end(DONE + 2) != DONE || obs_pf[DONE] !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_done: end cycle %0d pf %b want %0d 1",
               first_end(DONE + 2), obs_pf[DONE], DONE);
    end
  endtask

  initial begin
    pat[0] = SEED;
    for (int i = 1; i <= N; i++) pat[i] = lfsr_step(pat[i-1]);
    test_reset();
    test_idle_passthrough();
    test_pass_run();
    test_idle_passthrough();
    test_stuck_fault();
    test_idle_passthrough();
    test_reset_mid_run();
    test_idle_passthrough();
    test_start_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
